// File: rtl/video_rx_timing.sv
// RGB565 parallel-video receiver: measures line/frame geometry, declares lock once
// it has been stable, then forwards pixels tagged with their active-area coordinates.
module video_rx_timing #(
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0,
  parameter int unsigned LOCK_FRAMES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lcd_hs,
  input  logic        i_lcd_vs,
  input  logic        i_lcd_de,
  input  logic [15:0] i_lcd_rgb,
  output logic        o_pixel_valid,
  output logic [15:0] o_pixel_data,
  output logic [10:0] o_pixel_xpos,
  output logic [10:0] o_pixel_ypos,
  output logic        o_frame_start,
  output logic [10:0] o_h_total,
  output logic [10:0] o_h_disp,
  output logic [10:0] o_v_total,
  output logic [10:0] o_v_disp,
  output logic        o_locked
);

  localparam logic [3:0] LP_LOCK = LOCK_FRAMES[3:0];

  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'd2047) ? v : v + 11'd1;
  endfunction

  logic        r_hs, r_vs, r_de, r_hs_d, r_vs_d, r_de_d;
  logic [15:0] r_rgb;
  logic        w_hs_edge, w_vs_edge, w_de_rise, w_de_fall;
  logic [10:0] r_hcnt, r_line_len, r_xcnt, r_de_len, r_lcnt, r_ycnt;
  logic [10:0] w_line_len, w_de_len, w_lcnt, w_col;
  logic [43:0] r_stored, w_cand;
  logic        w_match;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_match_cnt, w_match_cnt_nxt, w_run;
  logic        r_valid, r_frame_start;
  logic [15:0] r_data;
  logic [10:0] r_xpos, r_ypos, r_h_total, r_h_disp, r_v_total, r_v_disp;

  // Input capture; syncs are stored already normalised to active-high
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_de   <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_rgb  <= 16'd0;
    end else begin
      r_hs   <= i_lcd_hs ^ ~HS_POL;
      r_vs   <= i_lcd_vs ^ ~VS_POL;
      r_de   <= i_lcd_de;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
      r_de_d <= r_de;
      r_rgb  <= i_lcd_rgb;
    end
  end

  assign w_hs_edge = r_hs & ~r_hs_d;
  assign w_vs_edge = r_vs & ~r_vs_d;
  assign w_de_rise = r_de & ~r_de_d;
  assign w_de_fall = ~r_de & r_de_d;

  // Same-cycle HS edge is folded into the candidate before VS clears the line count
  assign w_line_len = w_hs_edge ? sat_inc(r_hcnt) : r_line_len;
  assign w_de_len   = w_de_fall ? sat_inc(r_xcnt) : r_de_len;
  assign w_lcnt     = w_hs_edge ? sat_inc(r_lcnt) : r_lcnt;
  assign w_col      = w_de_rise ? 11'd0 : sat_inc(r_xcnt);
  assign w_cand     = {w_line_len, w_de_len, w_lcnt, r_ycnt};
  assign w_match    = (w_cand == r_stored);

  // Geometry counters and the stored previous-frame candidate
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hcnt     <= 11'd0;
      r_line_len <= 11'd0;
      r_xcnt     <= 11'd0;
      r_de_len   <= 11'd0;
      r_lcnt     <= 11'd0;
      r_ycnt     <= 11'd0;
      r_stored   <= 44'd0;
    end else begin
      r_hcnt     <= w_hs_edge ? 11'd0 : sat_inc(r_hcnt);
      r_line_len <= w_line_len;
      r_de_len   <= w_de_len;
      r_lcnt     <= w_vs_edge ? 11'd0 : w_lcnt;
      if (r_de) begin
        r_xcnt <= w_col;
      end
      if (w_vs_edge) begin
        r_ycnt <= 11'd0;
      end else if (w_de_fall) begin
        r_ycnt <= sat_inc(r_ycnt);
      end
      if (w_vs_edge) begin
        r_stored <= w_cand;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_WAIT_VS;
      r_match_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_cnt_nxt;
    end
  end

  // Lock FSM: w_run is the length of the current run of identical measurements
  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    w_run           = 4'd1;
    if (!w_match) begin
      w_run = 4'd1;
    end else if (r_match_cnt == 4'd15) begin
      w_run = r_match_cnt;
    end else begin
      w_run = r_match_cnt + 4'd1;
    end
    case (r_state)
      ST_WAIT_VS: begin
        if (w_vs_edge) begin
          w_state_nxt     = ST_MEASURE;
          w_match_cnt_nxt = 4'd0;
        end else begin
          w_state_nxt = ST_WAIT_VS;
        end
      end
      ST_MEASURE: begin
        if (w_vs_edge) begin
          w_match_cnt_nxt = w_run;
          w_state_nxt     = (w_run >= LP_LOCK) ? ST_LOCKED : ST_MEASURE;
        end else begin
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (w_vs_edge && !w_match) begin
          w_state_nxt     = ST_MEASURE;
          w_match_cnt_nxt = 4'd0;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt     = ST_WAIT_VS;
        w_match_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Output register stage; pixels gate on the post-update state so they align with locked
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_data        <= 16'd0;
      r_xpos        <= 11'd0;
      r_ypos        <= 11'd0;
      r_frame_start <= 1'b0;
      r_h_total     <= 11'd0;
      r_h_disp      <= 11'd0;
      r_v_total     <= 11'd0;
      r_v_disp      <= 11'd0;
    end else begin
      r_valid       <= r_de && (w_state_nxt == ST_LOCKED);
      r_data        <= r_rgb;
      r_xpos        <= w_col;
      r_ypos        <= r_ycnt;
      r_frame_start <= w_vs_edge;
      if (w_vs_edge) begin
        r_h_total <= w_cand[43:33];
        r_h_disp  <= w_cand[32:22];
        r_v_total <= w_cand[21:11];
        r_v_disp  <= w_cand[10:0];
      end
    end
  end

  assign o_pixel_valid = r_valid;
  assign o_pixel_data  = r_data;
  assign o_pixel_xpos  = r_xpos;
  assign o_pixel_ypos  = r_ypos;
  assign o_frame_start = r_frame_start;
  assign o_h_total     = r_h_total;
  assign o_h_disp      = r_h_disp;
  assign o_v_total     = r_v_total;
  assign o_v_disp      = r_v_disp;
  assign o_locked      = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_video_rx_timing.sv
// Randomised frame stream fed to an active-low and an active-high sync instance,
// checked cycle by cycle against a frame-level reference model.
module tb_video_rx_timing;
  localparam int LF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_n = 1'b1, vs_n = 1'b1, hs_p = 1'b0, vs_p = 1'b0, de = 1'b0;
  logic [15:0] rgb = 16'd0;

  logic a_valid, a_fs, a_lk, b_valid, b_fs, b_lk;
  logic [15:0] a_data, b_data;
  logic [10:0] a_x, a_y, a_ht, a_hd, a_vt, a_vd, b_x, b_y, b_ht, b_hd, b_vt, b_vd;

  always #5 clk = ~clk;

  video_rx_timing #(.HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LF)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_hs(hs_n), .i_lcd_vs(vs_n), .i_lcd_de(de),
    .i_lcd_rgb(rgb), .o_pixel_valid(a_valid), .o_pixel_data(a_data), .o_pixel_xpos(a_x),
    .o_pixel_ypos(a_y), .o_frame_start(a_fs), .o_h_total(a_ht), .o_h_disp(a_hd),
    .o_v_total(a_vt), .o_v_disp(a_vd), .o_locked(a_lk));

  video_rx_timing #(.HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_lcd_hs(hs_p), .i_lcd_vs(vs_p), .i_lcd_de(de),
    .i_lcd_rgb(rgb), .o_pixel_valid(b_valid), .o_pixel_data(b_data), .o_pixel_xpos(b_x),
    .o_pixel_ypos(b_y), .o_frame_start(b_fs), .o_h_total(b_ht), .o_h_disp(b_hd),
    .o_v_total(b_vt), .o_v_disp(b_vd), .o_locked(b_lk));

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic        lk;
    logic        mk;
    logic [10:0] ht, hd, vt, vd;
  } exp_t;

  exp_t e0, e1;
  int   n_checks = 0, n_pass = 0;
  int   npix_exp = 0, npix_a = 0, npix_b = 0;

  // Frame-level model: 0 = waiting for VS, 1 = measuring, 2 = locked
  int m_state, m_run;
  bit m_prev_known, m_meas_known, cur_known;
  int m_prev[4], m_meas[4], cur[4], nxt[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, want);
  endtask

  task automatic check_dut(input string p, input logic v, input logic [15:0] d,
                           input logic [10:0] x, input logic [10:0] y, input logic fs,
                           input logic lk, input logic [10:0] ht, input logic [10:0] hd,
                           input logic [10:0] vt, input logic [10:0] vd);
    chk({p, "pixel_valid"}, 32'(v), 32'(e1.valid));
    chk({p, "frame_start"}, 32'(fs), 32'(e1.fs));
    chk({p, "locked"}, 32'(lk), 32'(e1.lk));
    if (e1.valid) begin
      chk({p, "pixel_data"}, 32'(d), 32'(e1.data));
      chk({p, "xpos"}, 32'(x), 32'(e1.x));
      chk({p, "ypos"}, 32'(y), 32'(e1.y));
    end
    if (e1.mk) begin
      chk({p, "h_total"}, 32'(ht), 32'(e1.ht));
      chk({p, "h_disp"}, 32'(hd), 32'(e1.hd));
      chk({p, "v_total"}, 32'(vt), 32'(e1.vt));
      chk({p, "v_disp"}, 32'(vd), 32'(e1.vd));
    end
  endtask

  task automatic check_outputs();
    check_dut("a_", a_valid, a_data, a_x, a_y, a_fs, a_lk, a_ht, a_hd, a_vt, a_vd);
    check_dut("b_", b_valid, b_data, b_x, b_y, b_fs, b_lk, b_ht, b_hd, b_vt, b_vd);
    if (e1.valid) npix_exp++;
    if (a_valid) npix_a++;
    if (b_valid) npix_b++;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_run = 0;
    m_prev_known = 1'b0;
    m_meas_known = 1'b1;
    m_meas = '{0, 0, 0, 0};
    cur_known = 1'b0;
  endtask

  // A VS edge reports the frame that just ended; a partial frame never equals anything
  task automatic model_vs_edge();
    bit same;
    same = cur_known && m_prev_known;
    for (int i = 0; i < 4; i++) if (cur[i] != m_prev[i]) same = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      m_run = 0;
    end else if (m_state == 1) begin
      m_run = same ? ((m_run < 15) ? m_run + 1 : 15) : 1;
      if (m_run >= LF) m_state = 2;
    end else if (!same) begin
      m_state = 1;
      m_run = 0;
    end
    m_prev_known = cur_known;
    m_prev = cur;
    m_meas_known = cur_known;
    m_meas = cur;
    cur = nxt;
    cur_known = 1'b1;
  endtask

  task automatic drive(input bit hs_a, input bit vs_a, input bit de_i, input logic [15:0] px,
                       input bit vs_edge, input int x, input int y);
    exp_t e;
    @(negedge clk);
    check_outputs();
    if (vs_edge) model_vs_edge();
    e = '0;
    e.fs = vs_edge;
    e.lk = (m_state == 2);
    e.valid = de_i && e.lk;
    e.data = px;
    e.x = 11'(x);
    e.y = 11'(y);
    e.mk = m_meas_known;
    e.ht = 11'(m_meas[0]);
    e.hd = 11'(m_meas[1]);
    e.vt = 11'(m_meas[2]);
    e.vd = 11'(m_meas[3]);
    rst_n = 1'b1;
    hs_n = ~hs_a; hs_p = hs_a;
    vs_n = ~vs_a; vs_p = vs_a;
    de = de_i;
    rgb = px;
    e1 = e0;
    e0 = e;
  endtask

  // One-clock reset: everything already in the pipe is flushed to zero
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    hs_n = 1'b1; hs_p = 1'b0; vs_n = 1'b1; vs_p = 1'b0; de = 1'b0;
    e1 = '0;
    e1.mk = 1'b1;
    e0 = e1;
    model_reset();
  endtask

  // Sync pulses 2 clocks / 2 lines wide, back porch 4 clocks / 2 lines
  task automatic run_frame(input int ht, input int hd, input int vt, input int vd,
                           input int vs_off, input int rst_pos);
    nxt = '{ht, hd, vt, vd};
    for (int l = 0; l < vt; l++) begin
      for (int c = 0; c < ht; c++) begin
        int p;
        bit hs_a, vs_a, de_i;
        p = l * ht + c;
        hs_a = (c < 2);
        vs_a = (p >= vs_off) && (p < vs_off + 2 * ht);
        de_i = (l >= 2) && (l < 2 + vd) && (c >= 4) && (c < 4 + hd);
        if (p == rst_pos) do_reset();
        else drive(hs_a, vs_a, de_i, 16'($urandom), (p == vs_off), c - 4, l - 2);
      end
    end
  endtask

  function automatic int rand_rst_pos(input int ht, input int vt);
    return $urandom_range(3, vt - 2) * ht + $urandom_range(3, ht - 2);
  endfunction

  initial begin
    bit big;
    int off, rp;
    e0 = '0;
    e1 = '0;
    model_reset();
    repeat (3) do_reset();
    repeat (5) drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0, 0);

    repeat (6) run_frame(20, 12, 10, 6, 0, -1);
    run_frame(20, 11, 10, 6, 0, -1);
    repeat (5) run_frame(20, 12, 10, 6, 0, -1);
    repeat (5) run_frame(24, 16, 12, 8, 7, -1);
    run_frame(20, 12, 10, 6, 0, rand_rst_pos(20, 10));
    repeat (6) run_frame(20, 12, 10, 6, 0, -1);

    big = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 4) == 0) big = ~big;
      off = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 9));
      if (big) begin
        rp = ($urandom_range(0, 6) == 0) ? rand_rst_pos(24, 12) : -1;
        run_frame(24, 16, 12, 8, off, rp);
      end else begin
        rp = ($urandom_range(0, 6) == 0) ? rand_rst_pos(20, 10) : -1;
        run_frame(20, 12, 10, 6, off, rp);
      end
    end

    repeat (4) drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0, 0);
    chk("a_pixel_count", 32'(npix_a), 32'(npix_exp));
    chk("b_pixel_count", 32'(npix_b), 32'(npix_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
